lms_err_monitor: RTL and testbench
==================================

# lms_err_monitor

Convergence monitor placed directly downstream of the pipelined two-tap LMS FIR. It consumes the filter's 32-bit error output, forms a saturated squared error, and tracks error power with a leaky integrator. A four-state FSM reports when adaptation has locked, has lost lock, or has diverged. Control logic and the host use `converged` and `alarm` to gate the step size or restart training.

## Interface
- `K`, 4: leak shift; power update is p += (sq − p) >>> K.
- `WARMUP`, 64: number of power updates ignored after reset or clear.
- `HOLD`, 16: consecutive below-`TH_LO` updates required to declare lock.
- `TH_LO`, 32'd4096: lock threshold; strict `<`.
- `TH_HI`, 32'd16384: unlock threshold; strict `>`.
- `TH_ALARM`, 32'd1<<28: divergence threshold; strict `>`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `e_in` in 32: signed error sample from the FIR.
- `in_valid` in 1: `e_in` is valid this cycle; tie high for a free-running filter.
- `clr_alarm` in 1: single-cycle pulse; clears the monitor.
- `pwr_out` out 32: unsigned error power p; reset value 0.
- `pwr_valid` out 1: pulses for one cycle when `pwr_out` updates; reset value 0.
- `state_out` out 2: WARMUP=0, TRAIN=1, LOCK=2, ALARM=3; reset value 0.
- `converged` out 1: high iff state is LOCK; reset value 0.
- `alarm` out 1: high iff state is ALARM; reset value 0.

## Operation
- **Stage 1.** Saturate signed `e_in` to 16 bits, giving es in [−32768, 32767]. Register es and `in_valid`.
- **Stage 2.** sq = es·es as a 32-bit unsigned value; the maximum is 2^30, so there is no overflow. Register sq and valid.
- **Stage 3.** When valid, compute the 33-bit signed difference d = sq − p. Then p ← p + (d >>> K), using an arithmetic shift (floor). Assert `pwr_valid`.
- **Rounding behaviour.** Because the shift floors, a falling p reaches the target exactly. A rising p stalls up to 2^K − 1 below the target.
- **FSM evaluation.** The FSM evaluates only in cycles where `pwr_valid` is high, using the new p. The hold counter and warmup counter advance only on those cycles.
- **WARMUP.** Count updates. On the `WARMUP`-th update, go to TRAIN and clear the hold counter.
- **TRAIN.** If p < `TH_LO`, increment the hold counter; otherwise clear it. When the count reaches `HOLD`, go to LOCK.
- **LOCK.** If p > `TH_HI` on a single update, go to TRAIN and clear the hold counter. Values between the thresholds keep LOCK (hysteresis).
- **Alarm entry.** From TRAIN or LOCK, p > `TH_ALARM` goes to ALARM. This takes priority over every other transition in the same update. WARMUP never raises the alarm.
- **ALARM.** Sticky. p keeps updating; the state is unchanged until `clr_alarm`.
- **`clr_alarm`.** Acts in any state and has priority over everything, including a same-cycle update. In-flight pipeline valids are dropped, p ← 0, both counters ← 0, state ← WARMUP.
- **Reset.** Asserting `rst_n` low mid-operation immediately zeroes all pipeline registers, p, the counters and every output.

## Timing
- **Pipeline latency.** `e_in`/`in_valid` sampled at edge n → `pwr_out` and `pwr_valid` change after edge n+2, i.e. visible in cycle n+3.
- **FSM latency.** The state reacts on the same edge that writes p, because the FSM compares the next-p value. `state_out`, `converged` and `alarm` therefore change in the same cycle as `pwr_out`.
- **Throughput.** One sample per clock. Gaps in `in_valid` propagate as gaps in `pwr_valid`.
- **Clear timing.** `clr_alarm` high at edge m → outputs show state WARMUP with p = 0 from cycle m+1. Samples accepted before m never update p.
- **Outputs.** All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **`lms_mon_pkg`.** Holds the state enum, the width constants (`EW`=32, `SW`=16, `PW`=32) and the saturate function.
- **`lms_err_square`.** One sub-module covering stages 1–2: saturation and squaring with the valid pipeline, including its own valid flush on clear.
- **Top level.** Contains the leaky integrator, the counters and the FSM.

## Test plan
- **Warmup, then lock.** Reset, then constant `e_in` = 16 (sq = 256) with `in_valid` = 1 → `state_out` = 1 after 64 updates. `converged` = 1 after 16 further updates (p ≤ 256 < 4096). `pwr_valid` first high in cycle 3.
- **Loss of lock.** Step `e_in` to 256 while in LOCK (sq = 65536) → p rises and the first update with p > 16384 returns the state to TRAIN. p settles in [65521, 65536].
- **Divergence and clear.** `e_in` = 0x7FFF_FFFF, saturated to 32767 → alarm once p > 2^28. Then pulse `clr_alarm` → next cycle shows p = 0 and state WARMUP.
- **Saturation.** `e_in` = −2^31 → sq = 2^30. `e_in` = −32768 → sq = 2^30. `e_in` = −5 → sq = 25.
- **Gapped input.** `in_valid` 1-0-1 pattern → `pwr_valid` shows the same pattern delayed 3 cycles, and counters advance only on valid updates.
- **Asynchronous reset.** Assert `rst_n` low between clock edges while in LOCK → all outputs 0 immediately. After release, recovery proceeds as in the first scenario.

Source files
------------

// File: rtl/lms_mon_pkg.sv
// Shared types, widths and the error saturation helper for the LMS convergence monitor.
package lms_mon_pkg;

  localparam int EW = 32;
  localparam int SW = 16;
  localparam int PW = 32;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCK   = 2'd2,
    ST_ALARM  = 2'd3
  } mon_state_t;

  // Clamp a signed EW-bit error to the signed SW-bit range.
  function automatic logic signed [SW-1:0] sat_es(input logic signed [EW-1:0] x);
    logic [EW-SW:0] top;
    top = x[EW-1:SW-1];
    if ((&top) || !(|top))
      sat_es = x[SW-1:0];
    else if (x[EW-1])
      sat_es = {1'b1, {(SW-1){1'b0}}};
    else
      sat_es = {1'b0, {(SW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/lms_err_square.sv
// Stages 1-2 of the monitor: saturate the FIR error to 16 bits, then square it.
module lms_err_square
  import lms_mon_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [EW-1:0] e_in,
  input  logic          in_valid,
  output logic [PW-1:0] sq,
  output logic          sq_valid
);

  logic signed [SW-1:0] es;
  logic                 es_valid;
  logic signed [PW-1:0] es_wide;
  logic signed [PW-1:0] prod;

  // Max magnitude is 2^30, so the 32-bit product never wraps.
  assign es_wide = {{(PW-SW){es[SW-1]}}, es};
  assign prod    = es_wide * es_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      es       <= '0;
      es_valid <= 1'b0;
      sq       <= '0;
      sq_valid <= 1'b0;
    end else begin
      es       <= sat_es(e_in);
      es_valid <= in_valid & ~clr;
      sq       <= prod;
      sq_valid <= es_valid & ~clr;
    end
  end

endmodule

// File: rtl/lms_err_monitor.sv
// Error-power leaky integrator and lock/divergence FSM for the two-tap LMS FIR.
//   state     | meaning
//   ST_WARMUP | ignoring the first WARMUP power updates
//   ST_TRAIN  | adapting; counting consecutive updates with p < TH_LO
//   ST_LOCK   | converged; leaves only when p > TH_HI or p > TH_ALARM
//   ST_ALARM  | diverged; sticky until clr_alarm
module lms_err_monitor
  import lms_mon_pkg::*;
#(
  parameter int            K        = 4,
  parameter int            WARMUP   = 64,
  parameter int            HOLD     = 16,
  parameter logic [PW-1:0] TH_LO    = 32'd4096,
  parameter logic [PW-1:0] TH_HI    = 32'd16384,
  parameter logic [PW-1:0] TH_ALARM = 32'h1000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [EW-1:0] e_in,
  input  logic          in_valid,
  input  logic          clr_alarm,
  output logic [PW-1:0] pwr_out,
  output logic          pwr_valid,
  output logic [1:0]    state_out,
  output logic          converged,
  output logic          alarm
);

  localparam int WCW = $clog2(WARMUP + 1);
  localparam int HCW = $clog2(HOLD + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

  logic [PW-1:0]      sq;
  logic               sq_valid;
  logic signed [PW:0] diff;
  logic signed [PW:0] step;
  logic [PW:0]        p_sum;
  logic [WCW-1:0]     warm_cnt;
  logic [HCW-1:0]     hold_cnt;
  mon_state_t         state;

  lms_err_square u_sq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_alarm),
    .e_in     (e_in),
    .in_valid (in_valid),
    .sq       (sq),
    .sq_valid (sq_valid)
  );

  // Flooring shift: a falling p lands on sq exactly, a rising p may stall short.
  always_comb begin
    diff  = $signed({1'b0, sq}) - $signed({1'b0, pwr_out});
    step  = diff >>> K;
    p_sum = {1'b0, pwr_out} + step;
  end

  assign state_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_out   <= '0;
      pwr_valid <= 1'b0;
      warm_cnt  <= '0;
      hold_cnt  <= '0;
      state     <= ST_WARMUP;
      converged <= 1'b0;
      alarm     <= 1'b0;
    end else if (clr_alarm) begin
      pwr_out   <= '0;
      pwr_valid <= 1'b0;
      warm_cnt  <= '0;
      hold_cnt  <= '0;
      state     <= ST_WARMUP;
      converged <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      pwr_valid <= sq_valid;
      if (sq_valid) begin
        pwr_out <= p_sum[PW-1:0];
        unique case (state)
          ST_WARMUP: begin
            if (warm_cnt == WARM_LAST) begin
              state    <= ST_TRAIN;
              hold_cnt <= '0;
            end else begin
              warm_cnt <= warm_cnt + WCW'(1);
            end
          end
          ST_TRAIN: begin
            if (p_sum > {1'b0, TH_ALARM}) begin
              state <= ST_ALARM;
              alarm <= 1'b1;
            end else if (p_sum < {1'b0, TH_LO}) begin
              hold_cnt <= hold_cnt + HCW'(1);
              if (hold_cnt == HOLD_LAST) begin
                state     <= ST_LOCK;
                converged <= 1'b1;
              end
            end else begin
              hold_cnt <= '0;
            end
          end
          ST_LOCK: begin
            if (p_sum > {1'b0, TH_ALARM}) begin
              state     <= ST_ALARM;
              alarm     <= 1'b1;
              converged <= 1'b0;
            end else if (p_sum > {1'b0, TH_HI}) begin
              state     <= ST_TRAIN;
              converged <= 1'b0;
              hold_cnt  <= '0;
            end
          end
          ST_ALARM: begin
          end
          default: begin
            state <= ST_WARMUP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lms_err_monitor.sv
// Directed bench for lms_err_monitor: lock sequence, unlock, divergence, saturation, gaps, async reset.
module tb_lms_err_monitor;

  logic        clk;
  logic        rst_n;
  logic [31:0] e_in;
  logic        in_valid;
  logic        clr_alarm;
  logic [31:0] pwr_out;
  logic        pwr_valid;
  logic [1:0]  state_out;
  logic        converged;
  logic        alarm;

  int n_chk  = 0;
  int n_pass = 0;

  lms_err_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e_in      (e_in),
    .in_valid  (in_valid),
    .clr_alarm (clr_alarm),
    .pwr_out   (pwr_out),
    .pwr_valid (pwr_valid),
    .state_out (state_out),
    .converged (converged),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_alarm = 1'b1;
    cyc();
    clr_alarm = 1'b0;
  endtask

  // Expects p = 0, counters cleared, e_in = 16 and in_valid = 1 already driven.
  task automatic run_lock_seq(input string tag);
    int cnt;
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!pwr_valid && cnt < 10);
    chk({tag, "_latency"}, cnt, 3);
    chk({tag, "_p_first"}, pwr_out, 16);
    repeat (62) cyc();
    chk({tag, "_warm_63"}, state_out, 0);
    cyc();
    chk({tag, "_train_64"}, state_out, 1);
    repeat (15) cyc();
    chk({tag, "_conv_79"}, converged, 0);
    cyc();
    chk({tag, "_conv_80"}, converged, 1);
    chk({tag, "_lock_state"}, state_out, 2);
    chk({tag, "_p_range"}, (pwr_out >= 241 && pwr_out <= 256), 1);
    chk({tag, "_pv_steady"}, pwr_valid, 1);
  endtask

  task automatic one_sample(input string tag, input logic [31:0] e, input logic [31:0] exp_p);
    int cnt;
    e_in     = e;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cnt = 0;
    while (!pwr_valid && cnt < 6) begin
      cyc();
      cnt++;
    end
    chk({tag, "_seen"}, pwr_valid, 1);
    chk({tag, "_p"}, pwr_out, exp_p);
    pulse_clr();
  endtask

  initial begin : stim
    logic [31:0] prev;
    logic        any_pv;
    logic [4:0]  pat;
    logic [7:0]  obs;
    logic [7:0]  exp_obs;
    int          cnt;

    rst_n     = 1'b0;
    e_in      = 32'd0;
    in_valid  = 1'b0;
    clr_alarm = 1'b0;
    repeat (3) cyc();
    chk("rst_p", pwr_out, 0);
    chk("rst_pv", pwr_valid, 0);
    chk("rst_state", state_out, 0);
    chk("rst_conv", converged, 0);
    chk("rst_alarm", alarm, 0);

    // Warmup then lock
    e_in     = 32'd16;
    in_valid = 1'b1;
    rst_n    = 1'b1;
    run_lock_seq("lock1");

    // Loss of lock: first update above TH_HI returns to TRAIN
    e_in = 32'd256;
    prev = pwr_out;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (state_out != 2'd2) break;
      prev = pwr_out;
    end
    chk("unlock_state", state_out, 1);
    chk("unlock_above", pwr_out > 32'd16384, 1);
    chk("unlock_first", prev <= 32'd16384, 1);
    repeat (400) cyc();
    chk("settle_range", (pwr_out >= 65521 && pwr_out <= 65536), 1);
    chk("settle_train", state_out, 1);

    // Divergence with a saturated input
    e_in = 32'h7FFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (alarm) break;
    end
    chk("alarm_set", alarm, 1);
    chk("alarm_state", state_out, 3);
    chk("alarm_p", pwr_out > 32'h1000_0000, 1);
    chk("alarm_conv", converged, 0);
    prev = pwr_out;
    repeat (20) cyc();
    chk("alarm_sticky", alarm, 1);
    chk("alarm_p_grows", pwr_out > prev, 1);

    // Clear drops in-flight samples
    in_valid = 1'b0;
    pulse_clr();
    chk("clr_p", pwr_out, 0);
    chk("clr_state", state_out, 0);
    chk("clr_alarm_out", alarm, 0);
    chk("clr_pv", pwr_valid, 0);
    any_pv = 1'b0;
    repeat (3) begin
      cyc();
      any_pv = any_pv | pwr_valid;
    end
    chk("clr_flush", any_pv, 0);
    chk("clr_p_hold", pwr_out, 0);

    // Saturation: p = sq >> 4 from p = 0
    one_sample("sat_min32", 32'h8000_0000, 32'd67108864);
    one_sample("sat_min16", 32'hFFFF_8000, 32'd67108864);
    one_sample("sat_m32769", 32'hFFFF_7FFF, 32'd67108864);
    one_sample("sat_40000", 32'd40000, 32'd67104768);
    one_sample("sat_m5", 32'hFFFF_FFFB, 32'd1);

    // Gapped input: pwr_valid echoes in_valid two edges later
    e_in    = 32'd4;
    pat     = 5'b01101;
    exp_obs = 8'd0;
    for (int k = 0; k < 5; k++) exp_obs[k+2] = pat[k];
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 5) ? pat[k] : 1'b0;
      cyc();
      obs[k] = pwr_valid;
    end
    chk("gap_pattern", obs, exp_obs);
    in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (pwr_valid) cnt++;
      if (state_out == 2'd1) break;
    end
    chk("gap_warm_rest", cnt, 61);

    // Lock, then async reset mid-cycle
    e_in = 32'd16;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (converged) break;
    end
    chk("pre_rst_lock", converged, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_p", pwr_out, 0);
    chk("arst_pv", pwr_valid, 0);
    chk("arst_state", state_out, 0);
    chk("arst_conv", converged, 0);
    chk("arst_alarm", alarm, 0);
    #2;
    rst_n = 1'b1;
    run_lock_seq("lock2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
